// File: rtl/mem_access_arbiter.sv
// Arbitrates a single-port synchronous memory between a CPU port and a host port,
// and runs a whole-memory clear sweep. Optional build macro: ROUND_ROBIN_EN.
module mem_access_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned LAT_W = 3;
  localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(2 ** ADDR_W);
  localparam logic [LAT_W-1:0] RD_LAST = LAT_W'(MEM_RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD, CLEAR} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;

  state_t           state;
  owner_t           owner;
  logic             clr_pending;
  logic [CNT_W-1:0] clr_cnt;
  logic [LAT_W-1:0] rd_cnt;
  logic             cpu_cand;
  logic             host_cand;
  logic             pick_cpu;
  logic             pick_host;

`ifdef ROUND_ROBIN_EN
  // Set when the host won the most recent tie; resets to host so the CPU wins the first tie.
  logic             last_host;
`endif

  // A port whose ack is showing this cycle still holds its old request; ignore it.
  always_comb begin
    cpu_cand  = cpu_en && cpu_req && !cpu_ack;
    host_cand = host_req && !host_ack;
    pick_cpu  = cpu_cand;
    pick_host = host_cand && !cpu_cand;
`ifdef ROUND_ROBIN_EN
    if (cpu_cand && host_cand) begin
      pick_cpu  = last_host;
      pick_host = !last_host;
    end
`endif
  end

  assign cpu_stall = cpu_req && !cpu_ack;

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      clr_pending <= 1'b0;
      clr_cnt     <= '0;
      rd_cnt      <= '0;
      cpu_ack     <= 1'b0;
      host_ack    <= 1'b0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef ROUND_ROBIN_EN
      last_host   <= 1'b1;
`endif
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      clr_done <= 1'b0;
      if (clr_req) clr_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (clr_pending) begin
            // A clr_req seen in this same cycle queues a further sweep.
            clr_pending <= clr_req;
            state       <= CLEAR;
            owner       <= OWN_NONE;
            clr_busy    <= 1'b1;
            clr_cnt     <= CNT_W'(1);
            mem_en      <= 1'b1;
            mem_we      <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= '0;
          end else if (pick_cpu || pick_host) begin
            state     <= ACCESS;
            mem_en    <= 1'b1;
            owner     <= pick_cpu ? OWN_CPU : OWN_HOST;
            mem_we    <= pick_cpu ? cpu_we : host_we;
            mem_addr  <= pick_cpu ? cpu_addr : host_addr;
            mem_wdata <= pick_cpu ? cpu_wdata : host_wdata;
            // Writes complete in the ACCESS cycle itself.
            if (pick_cpu && cpu_we) cpu_ack <= 1'b1;
            if (pick_host && host_we) host_ack <= 1'b1;
`ifdef ROUND_ROBIN_EN
            if (cpu_cand && host_cand) last_host <= pick_host;
`endif
          end
        end

        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end else begin
            state  <= WAIT_RD;
            rd_cnt <= RD_LAST;
          end
        end

        WAIT_RD: begin
          if (rd_cnt == '0) begin
            if (owner == OWN_CPU) begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end else begin
              host_rdata <= mem_rdata;
              host_ack   <= 1'b1;
            end
            state <= IDLE;
            owner <= OWN_NONE;
          end else begin
            rd_cnt <= rd_cnt - LAT_W'(1);
          end
        end

        CLEAR: begin
          // clr_cnt runs one ahead of mem_addr; reaching DEPTH means the last word is on the bus.
          if (clr_cnt == DEPTH) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
          end else begin
            mem_addr <= clr_cnt[ADDR_W-1:0];
            clr_cnt  <= clr_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter with a 1-cycle-latency memory model.
module tb_mem_access_arbiter;

  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_RD_LAT = 1;
  localparam int unsigned DEPTH      = 4096;
  localparam int          BUDGET     = 6000;

  logic              main_clk = 1'b0;
  logic              reset;
  logic              cpu_en, cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              host_req, host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              clr_req, clr_busy, clr_done;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  mem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_RD_LAT(MEM_RD_LAT)) dut (
    .main_clk(main_clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 main_clk = ~main_clk;

  // Synchronous memory: read data appears the cycle after the mem_en read cycle.
  logic [DATA_W-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge main_clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge main_clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic              rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t host_q[$];
  int   clr_exp     = 0;
  int   clr_done_cyc = -1;
  exp_t ec, eh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack or clr_done must match a queued expectation.
  always @(negedge main_clk) begin
    if (cpu_ack) begin
      if (cpu_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cpu_ack_unexpected: got ack at cycle %0d expected none", cyc);
      end else begin
        ec = cpu_q.pop_front();
        checks++;
        if (ec.rd && cpu_rdata !== ec.data) begin
          failures++;
          $display("FAIL cpu_rdata: got 0x%08h expected 0x%08h", cpu_rdata, ec.data);
        end
      end
    end
    if (host_ack) begin
      if (host_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL host_ack_unexpected: got ack at cycle %0d expected none", cyc);
      end else begin
        eh = host_q.pop_front();
        checks++;
        if (eh.rd && host_rdata !== eh.data) begin
          failures++;
          $display("FAIL host_rdata: got 0x%08h expected 0x%08h", host_rdata, eh.data);
        end
      end
    end
    if (clr_done) begin
      checks++;
      clr_done_cyc = cyc;
      if (clr_exp == 0) begin
        failures++;
        $display("FAIL clr_done_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        clr_exp--;
      end
    end
  end

  task automatic cpu_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input logic [DATA_W-1:0] exp_rd, output int lat, output int ack_cyc);
    exp_t x;
    int t0;
    bit got;
    x.rd = !we; x.data = exp_rd;
    cpu_q.push_back(x);
    @(negedge main_clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    t0 = cyc; got = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge main_clk);
      if (cpu_ack) begin got = 1'b1; break; end
    end
    lat = cyc - t0; ack_cyc = cyc;
    cpu_req = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL cpu_timeout: got no ack for addr 0x%03h expected ack within %0d cycles", addr, BUDGET);
    end
  endtask

  task automatic host_txn(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic [DATA_W-1:0] exp_rd, output int lat, output int ack_cyc);
    exp_t x;
    int t0;
    bit got;
    x.rd = !we; x.data = exp_rd;
    host_q.push_back(x);
    @(negedge main_clk);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    t0 = cyc; got = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge main_clk);
      if (host_ack) begin got = 1'b1; break; end
    end
    lat = cyc - t0; ack_cyc = cyc;
    host_req = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL host_timeout: got no ack for addr 0x%03h expected ack within %0d cycles", addr, BUDGET);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  int lc, lh, ac, ah, busy_cnt, nz_cnt, stall_bad, en_cnt, ack_cnt;
  bit done, found;

  initial begin
    reset = 1'b1; cpu_en = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; clr_req = 1'b0;
    repeat (3) @(negedge main_clk);
    check("rst_cpu_ack",  32'(cpu_ack), 0);
    check("rst_host_ack", 32'(host_ack), 0);
    check("rst_cpu_stall", 32'(cpu_stall), 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_clr_done", 32'(clr_done), 0);
    check("rst_mem_en",   32'(mem_en), 0);
    check("rst_mem_we",   32'(mem_we), 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);
    reset = 1'b0;

    // Host-only write then read.
    host_txn(1'b1, 12'h005, 32'hDEADBEEF, 32'h0, lh, ah);
    check("host_wr_lat", 32'(lh), 1);
    host_txn(1'b0, 12'h005, 32'h0, 32'hDEADBEEF, lh, ah);
    check("host_rd_lat", 32'(lh), 3);
    check("cpu_rdata_hold", cpu_rdata, 0);

    // Simultaneous requests.
    cpu_en = 1'b1;
    fork
      cpu_txn(1'b1, 12'h010, 32'h11111111, 32'h0, lc, ac);
      host_txn(1'b1, 12'h020, 32'h22222222, 32'h0, lh, ah);
    join
    check("tie1_cpu_lat", 32'(lc), 1);
    check("tie1_host_lat", 32'(lh), 3);
    fork
      cpu_txn(1'b1, 12'h011, 32'h33333333, 32'h0, lc, ac);
      host_txn(1'b1, 12'h021, 32'h44444444, 32'h0, lh, ah);
    join
`ifdef ROUND_ROBIN_EN
    check("tie2_cpu_lat", 32'(lc), 3);
    check("tie2_host_lat", 32'(lh), 1);
`else
    check("tie2_cpu_lat", 32'(lc), 1);
    check("tie2_host_lat", 32'(lh), 3);
`endif
    cpu_txn(1'b0, 12'h010, 32'h0, 32'h11111111, lc, ac);
    check("cpu_rd_lat", 32'(lc), 3);
    host_txn(1'b0, 12'h021, 32'h0, 32'h44444444, lh, ah);
    cpu_txn(1'b0, 12'h020, 32'h0, 32'h22222222, lc, ac);
    check("host_rdata_hold", host_rdata, 32'h44444444);
    cpu_txn(1'b0, 12'h011, 32'h0, 32'h33333333, lc, ac);

    // CPU disabled while requesting: only the host reaches memory.
    cpu_en = 1'b0;
    fork
      begin
        @(negedge main_clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
        stall_bad = 0; en_cnt = 0; ack_cnt = 0;
        repeat (20) begin
          @(negedge main_clk);
          if (!cpu_stall) stall_bad++;
          if (mem_en) en_cnt++;
          if (cpu_ack) ack_cnt++;
        end
        cpu_req = 1'b0;
      end
      begin
        host_txn(1'b1, 12'h030, 32'h55555555, 32'h0, lh, ah);
        host_txn(1'b1, 12'h031, 32'h66666666, 32'h0, lh, ah);
      end
    join
    check("dis_stall_drops", 32'(stall_bad), 0);
    check("dis_cpu_acks", 32'(ack_cnt), 0);
    check("dis_mem_en_cycles", 32'(en_cnt), 2);
    cpu_en = 1'b1;

    // Full clear sweep.
    cpu_txn(1'b1, 12'h000, 32'h00000001, 32'h0, lc, ac);
    cpu_txn(1'b1, 12'h7FF, 32'h000007FF, 32'h0, lc, ac);
    cpu_txn(1'b1, 12'hFFF, 32'hFFFFFFFF, 32'h0, lc, ac);
    clr_exp++;
    @(negedge main_clk); clr_req = 1'b1;
    @(negedge main_clk); clr_req = 1'b0;
    busy_cnt = 0; nz_cnt = 0; done = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (clr_busy) busy_cnt++;
      if (clr_busy && (!mem_en || !mem_we || mem_wdata != '0)) nz_cnt++;
      if (clr_done) begin done = 1'b1; break; end
      @(negedge main_clk);
    end
    check("clr_busy_cycles", 32'(busy_cnt), DEPTH);
    check("clr_bad_writes", 32'(nz_cnt), 0);
    check("clr_done_seen", 32'(done), 1);
    cpu_txn(1'b0, 12'h000, 32'h0, 32'h0, lc, ac);
    cpu_txn(1'b0, 12'h7FF, 32'h0, 32'h0, lc, ac);
    host_txn(1'b0, 12'hFFF, 32'h0, 32'h0, lh, ah);
    check("clr_host_rdata", host_rdata, 0);

    // Clear requested during a CPU read; host must wait for the sweep.
    cpu_txn(1'b1, 12'h123, 32'hCAFEF00D, 32'h0, lc, ac);
    fork
      cpu_txn(1'b0, 12'h123, 32'h0, 32'hCAFEF00D, lc, ac);
      begin
        @(negedge main_clk);
        @(negedge main_clk);
        clr_exp++;
        clr_req = 1'b1;
        @(negedge main_clk);
        clr_req = 1'b0;
        host_txn(1'b1, 12'h300, 32'h00000077, 32'h0, lh, ah);
      end
    join
    check("clr_mid_read_lat", 32'(lc), 3);
    check("host_after_clr_done", 32'(ah > clr_done_cyc), 1);
    host_txn(1'b0, 12'h300, 32'h0, 32'h00000077, lh, ah);
    cpu_txn(1'b0, 12'h123, 32'h0, 32'h0, lc, ac);

    // Reset mid-sweep.
    cpu_txn(1'b1, 12'h200, 32'h5A5A5A5A, 32'h0, lc, ac);
    @(negedge main_clk); clr_req = 1'b1;
    @(negedge main_clk); clr_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge main_clk);
      if (mem_en && mem_addr == 12'h100) begin found = 1'b1; break; end
    end
    check("rst_sweep_reached", 32'(found), 1);
    reset = 1'b1;
    @(negedge main_clk);
    check("rst_mid_busy", 32'(clr_busy), 0);
    check("rst_mid_done", 32'(clr_done), 0);
    check("rst_mid_mem_en", 32'(mem_en), 0);
    reset = 1'b0;
    done = 1'b0;
    repeat (8) begin
      @(negedge main_clk);
      if (clr_done || clr_busy) done = 1'b1;
    end
    check("rst_no_resume", 32'(done), 0);
    cpu_txn(1'b0, 12'h200, 32'h0, 32'h5A5A5A5A, lc, ac);

    repeat (3) @(negedge main_clk);
    check("cpu_q_drained", 32'(cpu_q.size()), 0);
    check("host_q_drained", 32'(host_q.size()), 0);
    check("clr_exp_drained", 32'(clr_exp), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
